// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing description for the multi-mode VGA timing generator.
//   mode_t   : one video mode (active size, porches, sync widths, polarities;
//              polarity 1 = sync asserted high, 0 = asserted low).
//   MODES    : the built-in mode table, indexed by mode number.
//   htotal/vtotal and the sync-boundary helpers derive the per-axis
//   thresholds from a mode_t so every user computes them the same way.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] width;
        logic [15:0] hfront;
        logic [15:0] hsync;
        logic [15:0] hback;
        logic [15:0] height;
        logic [15:0] vfront;
        logic [15:0] vsync;
        logic [15:0] vback;
        logic        hpol;
        logic        vpol;
    } mode_t;

    localparam int MODE_COUNT = 2;

    // 720x480: HTOTAL 896, VTOTAL 499, negative hsync, positive vsync
    localparam mode_t MODE_720X480 = '{
        width: 16'd720, hfront: 16'd24, hsync: 16'd64, hback: 16'd88,
        height: 16'd480, vfront: 16'd3, vsync: 16'd10, vback: 16'd6,
        hpol: 1'b0, vpol: 1'b1
    };

    // 640x480: HTOTAL 800, VTOTAL 525, both syncs negative
    localparam mode_t MODE_640X480 = '{
        width: 16'd640, hfront: 16'd16, hsync: 16'd96, hback: 16'd48,
        height: 16'd480, vfront: 16'd10, vsync: 16'd2, vback: 16'd33,
        hpol: 1'b0, vpol: 1'b0
    };

    // Packed array: index 0 is the rightmost element of the concatenation
    localparam mode_t [MODE_COUNT-1:0] MODES = {MODE_640X480, MODE_720X480};

    function automatic int unsigned htotal(mode_t m);
        return 32'(m.width) + 32'(m.hfront) + 32'(m.hsync) + 32'(m.hback);
    endfunction

    function automatic int unsigned vtotal(mode_t m);
        return 32'(m.height) + 32'(m.vfront) + 32'(m.vsync) + 32'(m.vback);
    endfunction

    function automatic int unsigned h_sync_start(mode_t m);
        return 32'(m.width) + 32'(m.hfront);
    endfunction

    function automatic int unsigned h_sync_end(mode_t m);
        return 32'(m.width) + 32'(m.hfront) + 32'(m.hsync);
    endfunction

    function automatic int unsigned v_sync_start(mode_t m);
        return 32'(m.height) + 32'(m.vfront);
    endfunction

    function automatic int unsigned v_sync_end(mode_t m);
        return 32'(m.height) + 32'(m.vfront) + 32'(m.vsync);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis: a counter that steps on inc and wraps after 'last',
//   plus decode of the active region and the sync region.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset (count -> 0)
//     inc             : step enable for this axis
//     active_len      : active-region length (region is cnt < active_len)
//     sync_start/end  : sync region is sync_start <= cnt < sync_end
//     last            : final count before wrapping to 0 (total - 1)
//     cnt             : current count
//     at_last         : cnt == last
//     at_pre_sync     : cnt == sync_start - 1 (the count before sync begins)
//     in_active       : cnt inside the active region
//     in_sync         : cnt inside the sync region (raw, polarity not applied)
//   Bounds are W+1 bits wide so that an end equal to 2^W is representable.
module vga_axis_counter
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic [W:0]   active_len,
    input  logic [W:0]   sync_start,
    input  logic [W:0]   sync_end,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         at_last,
    output logic         at_pre_sync,
    output logic         in_active,
    output logic         in_sync
);

    localparam int WB = W + 1;

    logic [W:0] cnt_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= at_last ? '0 : cnt + W'(1);
        end
    end

    assign cnt_w       = {1'b0, cnt};
    assign at_last     = (cnt == last);
    assign at_pre_sync = ((cnt_w + WB'(1)) == sync_start);
    assign in_active   = (cnt_w < active_len);
    assign in_sync     = (cnt_w >= sync_start) && (cnt_w < sync_end);

endmodule

// File: rtl/vga_timing_multi.sv
// vga_timing_multi
//   Multi-mode VGA raster timing generator. x/y walk the raster at one pixel
//   per advance cycle; the active mode can only change at a frame boundary.
//   Optional feature macro: VGA_TIMING_FRAME_CNT_EN (frame counter register;
//   when undefined, frame_cnt is tied to 0).
//   Parameters: NUM_MODES, XW, YW, FRAME_W, MODE_TABLE (defaults to MODES).
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     advance           : pixel-advance enable
//     mode_sel          : requested mode, sampled only on frame_start
//     x, y              : raster counters
//     hsync, vsync      : sync levels with the active mode's polarity
//     blank             : high outside the active area
//     hsync_pulse       : advance strobe one pixel before hsync asserts
//     vsync_pulse       : advance strobe at the end of the line before vsync
//     line_start        : advance strobe on the last pixel of a line
//     frame_start       : advance strobe on the last pixel of a frame
//     mode_active       : mode currently being generated
//     frame_cnt         : frame counter
module vga_timing_multi
    import vga_timing_pkg::*;
#(
    parameter int                    NUM_MODES  = 2,
    parameter int                    XW         = 11,
    parameter int                    YW         = 10,
    parameter int                    FRAME_W    = 8,
    parameter mode_t [NUM_MODES-1:0] MODE_TABLE = MODES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         advance,
    input  logic [$clog2(NUM_MODES)-1:0] mode_sel,
    output logic [XW-1:0]                x,
    output logic [YW-1:0]                y,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         blank,
    output logic                         hsync_pulse,
    output logic                         vsync_pulse,
    output logic                         line_start,
    output logic                         frame_start,
    output logic [$clog2(NUM_MODES)-1:0] mode_active,
    output logic [FRAME_W-1:0]           frame_cnt
);

    localparam int MW  = $clog2(NUM_MODES);
    localparam int MLW = MW + 1;
    localparam int XB  = XW + 1;
    localparam int YB  = YW + 1;
    localparam logic [MW:0] MODE_LIMIT = MLW'(NUM_MODES);

    // Reject tables whose totals cannot be represented by the counters
    if (NUM_MODES < 2) begin : g_num_modes_err
        $error("vga_timing_multi: NUM_MODES must be at least 2");
    end

    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode_chk
        if (htotal(MODE_TABLE[m]) > (2 ** XW)) begin : g_h_err
            $error("vga_timing_multi: HTOTAL of a mode exceeds 2**XW");
        end
        if (vtotal(MODE_TABLE[m]) > (2 ** YW)) begin : g_v_err
            $error("vga_timing_multi: VTOTAL of a mode exceeds 2**YW");
        end
    end

    logic [MW-1:0] mode_q;
    mode_t         cur;

    logic [XW:0]   h_len, h_sstart, h_send;
    logic [XW-1:0] h_last;
    logic [YW:0]   v_len, v_sstart, v_send;
    logic [YW-1:0] v_last;

    logic x_last, x_pre, x_act, x_sync;
    logic y_last, y_pre, y_act, y_sync;
    logic step;

    assign cur = MODE_TABLE[mode_q];

    assign h_len    = XB'(cur.width);
    assign h_sstart = XB'(h_sync_start(cur));
    assign h_send   = XB'(h_sync_end(cur));
    assign h_last   = XW'(htotal(cur) - 32'd1);

    assign v_len    = YB'(cur.height);
    assign v_sstart = YB'(v_sync_start(cur));
    assign v_send   = YB'(v_sync_end(cur));
    assign v_last   = YW'(vtotal(cur) - 32'd1);

    // Strobes are suppressed while reset is held so reset wins over advance
    assign step = advance && !reset;

    vga_axis_counter #(.W(XW)) u_x_axis (
        .clk         (clk),
        .reset       (reset),
        .inc         (advance),
        .active_len  (h_len),
        .sync_start  (h_sstart),
        .sync_end    (h_send),
        .last        (h_last),
        .cnt         (x),
        .at_last     (x_last),
        .at_pre_sync (x_pre),
        .in_active   (x_act),
        .in_sync     (x_sync)
    );

    vga_axis_counter #(.W(YW)) u_y_axis (
        .clk         (clk),
        .reset       (reset),
        .inc         (advance && x_last),
        .active_len  (v_len),
        .sync_start  (v_sstart),
        .sync_end    (v_send),
        .last        (v_last),
        .cnt         (y),
        .at_last     (y_last),
        .at_pre_sync (y_pre),
        .in_active   (y_act),
        .in_sync     (y_sync)
    );

    assign line_start  = step && x_last;
    assign frame_start = line_start && y_last;
    assign hsync_pulse = step && x_pre;
    assign vsync_pulse = line_start && y_pre;

    assign hsync = cur.hpol ? x_sync : ~x_sync;
    assign vsync = cur.vpol ? y_sync : ~y_sync;
    assign blank = ~(x_act && y_act);

    // The counters wrap to 0 on the same edge, so pixel (0,0) of the next
    // frame is already generated with the newly selected mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= '0;
        end else if (frame_start && ({1'b0, mode_sel} < MODE_LIMIT)) begin
            mode_q <= mode_sel;
        end
    end

    assign mode_active = mode_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
        end else if (frame_start) begin
            frame_q <= frame_q + FRAME_W'(1);
        end
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: doc/vga_timing_multi.md
VGA_TIMING_MULTI -- requirements
Module: vga_timing_multi

Interface
REQ-001 The block SHALL have parameter NUM_MODES, default 2, giving the number of selectable timing modes.
REQ-002 The block SHALL have parameter XW, default 11, giving the width of the x counter.
REQ-003 The block SHALL have parameter YW, default 10, giving the width of the y counter.
REQ-004 The block SHALL have parameter FRAME_W, default 8, giving the width of the frame counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port advance, input, 1 bit: pixel-advance enable.
REQ-008 The block SHALL have port mode_sel, input, $clog2(NUM_MODES) bits: the requested mode.
REQ-009 The block SHALL have port x, output, XW bits: horizontal counter.
REQ-010 The block SHALL have port y, output, YW bits: vertical counter.
REQ-011 The block SHALL have ports hsync and vsync, output, 1 bit each: sync levels with the active mode's polarity applied.
REQ-012 The block SHALL have port blank, output, 1 bit: high outside the active area.
REQ-013 The block SHALL have ports hsync_pulse, vsync_pulse, line_start and frame_start, output, 1 bit each: single-cycle strobes.
REQ-014 The block SHALL have port mode_active, output, $clog2(NUM_MODES) bits: the mode currently being generated.
REQ-015 The block SHALL have port frame_cnt, output, FRAME_W bits: the frame counter (see REQ-031).

Function
REQ-016 x SHALL count 0..HTOTAL-1, incrementing only on cycles where advance=1, and SHALL wrap to 0.
REQ-017 x order SHALL be: active area 0..WIDTH-1, front porch, sync, back porch.
REQ-018 y SHALL increment on cycles where advance=1 and x=HTOTAL-1, and SHALL wrap to 0 after VTOTAL-1.
REQ-019 hsync SHALL be asserted (at the mode's polarity) while WIDTH+HFRONT <= x < WIDTH+HFRONT+HSYNC.
REQ-020 vsync SHALL be asserted (at the mode's polarity) while HEIGHT+VFRONT <= y < HEIGHT+VFRONT+VSYNC.
REQ-021 blank SHALL be high when x>=WIDTH or y>=HEIGHT.
REQ-022 hsync, vsync and blank SHALL be combinational from the registered x, y and mode_active, adding zero latency.
REQ-023 hsync_pulse SHALL equal advance && x==WIDTH+HFRONT-1, one cycle before hsync asserts.
REQ-024 vsync_pulse SHALL equal advance && x==HTOTAL-1 && y==HEIGHT+VFRONT-1.
REQ-025 line_start SHALL equal advance && x==HTOTAL-1.
REQ-026 frame_start SHALL equal line_start && y==VTOTAL-1.
REQ-027 With advance=0, all counters and mode_active SHALL hold, and all strobes SHALL be 0.
REQ-028 mode_sel SHALL be sampled only on cycles where frame_start=1; mode_active SHALL take the sampled value on that edge, and x=0, y=0 SHALL then use the new mode's timing.
REQ-029 A mode_sel value >= NUM_MODES SHALL be ignored; mode_active SHALL be retained.
REQ-030 mode_sel changes mid-frame SHALL have no effect until frame_start; only the value present at frame_start counts.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL set x=0, y=0, mode_active=0 and frame_cnt=0, and all strobes SHALL be 0.
REQ-032 Reset mid-frame SHALL restart at x=0, y=0 on the following cycle, regardless of advance.
REQ-033 Reset SHALL take priority over advance.

Configuration
REQ-034 Macro VGA_TIMING_FRAME_CNT_EN defined: frame_cnt SHALL increment modulo 2^FRAME_W on each frame_start and clear on reset.
REQ-035 Macro VGA_TIMING_FRAME_CNT_EN undefined: frame_cnt SHALL be tied to 0 and no counter register SHALL exist.

Structure
REQ-036 Package vga_timing_pkg SHALL hold the struct type mode_t with fields width, hfront, hsync, hback, height, vfront, vsync, vback, hpol and vpol.
REQ-037 Package vga_timing_pkg SHALL hold the constant table MODES[NUM_MODES].
REQ-038 MODES[0] SHALL be 720x480: H 24/64/88 with hpol=0 (negative), V 3/10/6 with vpol=1; HTOTAL=896, VTOTAL=499.
REQ-039 MODES[1] SHALL be 640x480: H 16/96/48 with hpol=0, V 10/2/33 with vpol=0; HTOTAL=800, VTOTAL=525.
REQ-040 Sub-module vga_axis_counter SHALL implement one axis (count, wrap and region decode), instantiated once for x and once for y.
REQ-041 Elaboration SHALL fail if any mode's HTOTAL exceeds 2^XW or VTOTAL exceeds 2^YW.

Verification
REQ-042 Reset test: reset during x=300, y=200, then release with advance=1 -> the next cycles show x=0, y=0, then x=1; mode_active=0.
REQ-043 Mode 0 horizontal test: advance=1 continuously -> hsync_pulse at x=743, hsync=0 for x=744..807, line_start at x=895.
REQ-044 Mode 0 vertical test: full frame -> vsync=1 for y=483..492, vsync_pulse once per frame at y=482, x=895, and frame_start every 896*499 advances.
REQ-045 Mode switch test: mode_sel=1 mid-frame, then toggled to 0 and back to 1 before frame_start -> switch occurs only at frame_start; the next line wraps at x=799 and vsync=0 for y=490..491.
REQ-046 Stall test: advance pulsed at 1-in-3 -> x advances one count per advance=1, strobes occur only on advance=1 cycles, and outputs hold between them.
REQ-047 Frame counter test: VGA_TIMING_FRAME_CNT_EN defined and FRAME_W=2, run 5 frames -> frame_cnt sequence 1, 2, 3, 0, 1; with the macro undefined, frame_cnt stays 0.
